// File: rtl/pps_stamp_counter_if.sv
// rtl/pps_stamp_counter_if.sv - control/status bus between ipif_regs and pps_stamp_counter
interface pps_stamp_counter_if #(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int INC_WIDTH       = 40
);
  logic                       correction_mode;
  logic                       load_valid;
  logic [TIMESTAMP_WIDTH-1:0] load_value;
  logic                       cfg_inc_valid;
  logic [INC_WIDTH-1:0]       cfg_inc;
  logic [TIMESTAMP_WIDTH-1:0] stamp_counter;
  logic [TIMESTAMP_WIDTH-1:0] pps_snapshot;
  logic                       pps_snap_valid;
  logic [INC_WIDTH-1:0]       cur_inc;
  logic                       gps_connected;
  logic [1:0]                 sync_state;

  modport master (
    output correction_mode, load_valid, load_value, cfg_inc_valid, cfg_inc,
    input  stamp_counter, pps_snapshot, pps_snap_valid, cur_inc, gps_connected, sync_state
  );

  modport slave (
    input  correction_mode, load_valid, load_value, cfg_inc_valid, cfg_inc,
    output stamp_counter, pps_snapshot, pps_snap_valid, cur_inc, gps_connected, sync_state
  );
endinterface

// File: rtl/pps_stamp_counter.sv
// rtl/pps_stamp_counter.sv - PPS-disciplined seconds.fraction timestamp counter
module pps_stamp_counter #(
  parameter int              TIMESTAMP_WIDTH = 64,
  parameter int              FRAC_WIDTH      = 32,
  parameter int              ACC_EXT         = 8,
  parameter int              CLK_PER_SEC     = 160000000,
  parameter int              PPS_TOL         = 1600,
  parameter int              LOCK_COUNT      = 3,
  parameter int              INC_STEP        = 1,
  parameter longint unsigned DEFAULT_INC     =
    ((64'd1 << (FRAC_WIDTH + ACC_EXT)) + 64'(CLK_PER_SEC / 2)) / 64'(CLK_PER_SEC)
) (
  input  logic               axi_aclk,
  input  logic               axi_resetn,
  input  logic               pps_rx,
  pps_stamp_counter_if.slave bus
);
  localparam int INC_W   = FRAC_WIDTH + ACC_EXT;
  localparam int ACC_W   = TIMESTAMP_WIDTH + ACC_EXT;
  localparam int SEC_W   = TIMESTAMP_WIDTH - FRAC_WIDTH;
  localparam int PER_MAX = CLK_PER_SEC + PPS_TOL;
  localparam int PER_MIN = CLK_PER_SEC - PPS_TOL;
  localparam int PER_W   = $clog2(PER_MAX + 2);
  localparam int CNT_W   = $clog2(LOCK_COUNT + 1);

  localparam logic [PER_W:0]     PER_MAX_V = (PER_W + 1)'(PER_MAX);
  localparam logic [PER_W:0]     PER_MIN_V = (PER_W + 1)'(PER_MIN);
  localparam logic [CNT_W-1:0]   LOCK_LAST = CNT_W'(LOCK_COUNT - 1);
  localparam logic [INC_W-1:0]   INC_ONE   = INC_W'(1);
  localparam logic [INC_W-1:0]   INC_MAX   = {INC_W{1'b1}};
  localparam logic [INC_W-1:0]   INC_STP   = INC_W'(INC_STEP);
  localparam logic [INC_W-1:0]   INC_DEF   = INC_W'(DEFAULT_INC);

  typedef enum logic [1:0] {
    FREE_RUN = 2'd0,
    SYNCING  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  logic [2:0]                 pps_sync_q, pps_sync_d;
  logic                       pps_evt_q, pps_evt_d;
  logic [PER_W-1:0]           per_cnt_q, per_cnt_d;
  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           good_cnt_q, good_cnt_d;
  logic                       first_q, first_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [INC_W-1:0]           cur_inc_q, cur_inc_d;
  logic [TIMESTAMP_WIDTH-1:0] pps_snapshot_q, pps_snapshot_d;
  logic                       pps_snap_valid_q, pps_snap_valid_d;
  logic                       gps_connected_q, gps_connected_d;

  logic [PER_W:0]             period;
  logic                       pps_good;
  logic                       pps_missing;
  logic                       do_corr;
  logic                       frac_msb;
  logic [FRAC_WIDTH-1:0]      frac;
  logic [SEC_W-1:0]           seconds;
  logic [INC_W-1:0]           inc_up, inc_dn;

  always_comb begin
    // bits [1:0] synchronise pps_rx, bit [2] holds the previous level for edge detect
    pps_sync_d = {pps_sync_q[1:0], pps_rx};
    pps_evt_d  = pps_sync_q[1] & ~pps_sync_q[2];

    per_cnt_d   = pps_evt_q ? '0 : ((&per_cnt_q) ? per_cnt_q : per_cnt_q + 1'b1);
    period      = {1'b0, per_cnt_q} + 1'b1;
    pps_good    = first_q | ((period >= PER_MIN_V) && (period <= PER_MAX_V));
    pps_missing = {1'b0, per_cnt_q} > PER_MAX_V;

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    first_d    = first_q;
    if (pps_evt_q) begin
      first_d = 1'b0;
      case (state_q)
        FREE_RUN: if (pps_good) begin
          state_d    = SYNCING;
          good_cnt_d = '0;
        end
        SYNCING: begin
          if (!pps_good)                   good_cnt_d = '0;
          else if (good_cnt_q == LOCK_LAST) state_d   = LOCKED;
          else                             good_cnt_d = good_cnt_q + 1'b1;
        end
        LOCKED:  if (!pps_good) state_d = FREE_RUN;
        default: state_d = FREE_RUN;
      endcase
    end else if (pps_missing && state_q != FREE_RUN) begin
      state_d = FREE_RUN;
    end
    // the first pulse after losing lock has no trustworthy period to judge
    if (state_d == FREE_RUN && state_q != FREE_RUN) first_d = 1'b1;

    seconds  = acc_q[ACC_W-1:INC_W];
    frac     = acc_q[INC_W-1:ACC_EXT];
    frac_msb = acc_q[INC_W-1];
    do_corr  = pps_evt_q & pps_good & (state_q == LOCKED) & bus.correction_mode;

    if (bus.load_valid)   acc_d = {bus.load_value, {ACC_EXT{1'b0}}};
    else if (do_corr)     acc_d = {seconds + {{(SEC_W-1){1'b0}}, frac_msb}, {INC_W{1'b0}}};
    else                  acc_d = acc_q + ACC_W'(cur_inc_q);

    inc_up    = (cur_inc_q > INC_MAX - INC_STP) ? INC_MAX : cur_inc_q + INC_STP;
    inc_dn    = (cur_inc_q <= INC_STP) ? INC_ONE : cur_inc_q - INC_STP;
    cur_inc_d = cur_inc_q;
    if (bus.cfg_inc_valid)         cur_inc_d = (bus.cfg_inc == '0) ? INC_ONE : bus.cfg_inc;
    else if (do_corr && frac_msb)  cur_inc_d = inc_up;
    else if (do_corr && frac != '0) cur_inc_d = inc_dn;

    pps_snapshot_d   = pps_evt_q ? acc_q[ACC_W-1:ACC_EXT] : pps_snapshot_q;
    pps_snap_valid_d = pps_evt_q;
    gps_connected_d  = (state_d == LOCKED);
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      pps_sync_q       <= '0;
      pps_evt_q        <= 1'b0;
      per_cnt_q        <= '0;
      state_q          <= FREE_RUN;
      good_cnt_q       <= '0;
      first_q          <= 1'b1;
      acc_q            <= '0;
      cur_inc_q        <= INC_DEF;
      pps_snapshot_q   <= '0;
      pps_snap_valid_q <= 1'b0;
      gps_connected_q  <= 1'b0;
    end else begin
      pps_sync_q       <= pps_sync_d;
      pps_evt_q        <= pps_evt_d;
      per_cnt_q        <= per_cnt_d;
      state_q          <= state_d;
      good_cnt_q       <= good_cnt_d;
      first_q          <= first_d;
      acc_q            <= acc_d;
      cur_inc_q        <= cur_inc_d;
      pps_snapshot_q   <= pps_snapshot_d;
      pps_snap_valid_q <= pps_snap_valid_d;
      gps_connected_q  <= gps_connected_d;
    end
  end

  assign bus.stamp_counter  = acc_q[ACC_W-1:ACC_EXT];
  assign bus.pps_snapshot   = pps_snapshot_q;
  assign bus.pps_snap_valid = pps_snap_valid_q;
  assign bus.cur_inc        = cur_inc_q;
  assign bus.gps_connected  = gps_connected_q;
  assign bus.sync_state     = state_q;
endmodule

// File: tb/tb_pps_stamp_counter.sv
// tb/tb_pps_stamp_counter.sv - directed self-checking bench for pps_stamp_counter
module tb_pps_stamp_counter;
  localparam logic [63:0] INC0  = 64'd10995116278;  // round(2^40 / 100)
  localparam logic [63:0] INC1  = INC0 - 64'd1;
  localparam logic [63:0] INC2  = INC0 + 64'd1;
  localparam logic [63:0] ONE_S = 64'd1 << 40;

  logic clk;
  logic resetn;
  logic pps_rx;
  int   errors = 0;
  int   checks = 0;

  pps_stamp_counter_if #(.TIMESTAMP_WIDTH(64), .INC_WIDTH(40)) bus ();

  pps_stamp_counter #(
    .CLK_PER_SEC(100),
    .PPS_TOL    (2),
    .LOCK_COUNT (3)
  ) dut (
    .axi_aclk  (clk),
    .axi_resetn(resetn),
    .pps_rx    (pps_rx),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    pps_rx = 1'b0;
    bus.correction_mode = 1'b0;
    bus.load_valid      = 1'b0;
    bus.load_value      = '0;
    bus.cfg_inc_valid   = 1'b0;
    bus.cfg_inc         = '0;
    tick(2);
    resetn = 1'b1;
  endtask

  // Rising edge now; effects are sampled 4 negedges later; next rise is gap cycles after this one.
  task automatic pps_pulse(input int gap, output logic [1:0] st, output logic [63:0] stamp,
                           output logic [63:0] snap, output logic sv, output logic [39:0] inc);
    pps_rx = 1'b1;
    tick(4);
    st    = bus.sync_state;
    stamp = bus.stamp_counter;
    snap  = bus.pps_snapshot;
    sv    = bus.pps_snap_valid;
    inc   = bus.cur_inc;
    tick(1);
    pps_rx = 1'b0;
    tick(gap - 5);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    pps_rx = 1'b0;
    tick(2);
    checks++; if (bus.stamp_counter !== 64'd0) begin errors++; $display("FAIL reset_stamp: got %0h want 0", bus.stamp_counter); end
    checks++; if (bus.pps_snapshot !== 64'd0) begin errors++; $display("FAIL reset_snapshot: got %0h want 0", bus.pps_snapshot); end
    checks++; if (bus.pps_snap_valid !== 1'b0) begin errors++; $display("FAIL reset_snap_valid: got %0b want 0", bus.pps_snap_valid); end
    checks++; if (bus.cur_inc !== INC0[39:0]) begin errors++; $display("FAIL reset_cur_inc: got %0d want %0d", bus.cur_inc, INC0); end
    checks++; if (bus.gps_connected !== 1'b0) begin errors++; $display("FAIL reset_gps: got %0b want 0", bus.gps_connected); end
    checks++; if (bus.sync_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.sync_state); end
  endtask

  task automatic test_free_run();
    do_reset();
    tick(100);
    // 100 * INC0 = 2^40 + 24, so the stamp is exactly one second
    checks++; if (bus.stamp_counter !== 64'h1_0000_0000) begin errors++; $display("FAIL free_run_stamp: got %0h want 100000000", bus.stamp_counter); end
    checks++; if (bus.sync_state !== 2'd0) begin errors++; $display("FAIL free_run_state: got %0d want 0", bus.sync_state); end
    checks++; if (bus.gps_connected !== 1'b0) begin errors++; $display("FAIL free_run_gps: got %0b want 0", bus.gps_connected); end
  endtask

  task automatic test_lock_and_snap();
    logic [1:0] st; logic [63:0] stamp, snap; logic sv; logic [39:0] inc;
    do_reset();
    bus.correction_mode = 1'b1;
    pps_pulse(100, st, stamp, snap, sv, inc);
    checks++; if (st !== 2'd1) begin errors++; $display("FAIL lock_p1_state: got %0d want 1", st); end
    pps_pulse(100, st, stamp, snap, sv, inc);
    pps_pulse(100, st, stamp, snap, sv, inc);
    checks++; if (st !== 2'd1) begin errors++; $display("FAIL lock_p3_state: got %0d want 1", st); end
    pps_pulse(100, st, stamp, snap, sv, inc);
    checks++; if (st !== 2'd2) begin errors++; $display("FAIL lock_p4_state: got %0d want 2", st); end
    checks++; if (bus.gps_connected !== 1'b1) begin errors++; $display("FAIL lock_gps: got %0b want 1", bus.gps_connected); end
    // pulse 5: acc = 403*INC0 = 4.03 s -> snap down to 4 s, increment trimmed down
    pps_pulse(100, st, stamp, snap, sv, inc);
    checks++; if (stamp !== 64'h4_0000_0000) begin errors++; $display("FAIL snap_p5_stamp: got %0h want 400000000", stamp); end
    checks++; if (snap !== ((64'd403 * INC0) >> 8)) begin errors++; $display("FAIL snap_p5_snapshot: got %0h want %0h", snap, (64'd403 * INC0) >> 8); end
    checks++; if (sv !== 1'b1) begin errors++; $display("FAIL snap_p5_valid: got %0b want 1", sv); end
    checks++; if (inc !== INC1[39:0]) begin errors++; $display("FAIL snap_p5_inc: got %0d want %0d", inc, INC1); end
    // pulse 6: acc = 4 s + 99*INC1 (~4.99 s) -> round up to 5 s, trim back up
    pps_pulse(100, st, stamp, snap, sv, inc);
    checks++; if (stamp !== 64'h5_0000_0000) begin errors++; $display("FAIL snap_p6_stamp: got %0h want 500000000", stamp); end
    checks++; if (snap !== ((4 * ONE_S + 64'd99 * INC1) >> 8)) begin errors++; $display("FAIL snap_p6_snapshot: got %0h want %0h", snap, (4 * ONE_S + 64'd99 * INC1) >> 8); end
    checks++; if (inc !== INC0[39:0]) begin errors++; $display("FAIL snap_p6_inc: got %0d want %0d", inc, INC0); end
    checks++; if (bus.pps_snap_valid !== 1'b0) begin errors++; $display("FAIL snap_valid_width: got %0b want 0", bus.pps_snap_valid); end
  endtask

  task automatic test_bad_period();
    logic [1:0] st; logic [63:0] stamp, snap; logic sv; logic [39:0] inc;
    pps_pulse(104, st, stamp, snap, sv, inc);
    checks++; if (stamp !== 64'h6_0000_0000) begin errors++; $display("FAIL bad_p7_stamp: got %0h want 600000000", stamp); end
    checks++; if (inc !== INC2[39:0]) begin errors++; $display("FAIL bad_p7_inc: got %0d want %0d", inc, INC2); end
    pps_pulse(100, st, stamp, snap, sv, inc);
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL bad_p8_state: got %0d want 0", st); end
    checks++; if (stamp !== ((6 * ONE_S + 64'd104 * INC2) >> 8)) begin errors++; $display("FAIL bad_p8_no_snap: got %0h want %0h", stamp, (6 * ONE_S + 64'd104 * INC2) >> 8); end
    checks++; if (snap !== ((6 * ONE_S + 64'd103 * INC2) >> 8)) begin errors++; $display("FAIL bad_p8_snapshot: got %0h want %0h", snap, (6 * ONE_S + 64'd103 * INC2) >> 8); end
    checks++; if (inc !== INC2[39:0]) begin errors++; $display("FAIL bad_p8_inc: got %0d want %0d", inc, INC2); end
    checks++; if (bus.gps_connected !== 1'b0) begin errors++; $display("FAIL bad_gps: got %0b want 0", bus.gps_connected); end
    for (int i = 0; i < 3; i++) begin
      pps_pulse(100, st, stamp, snap, sv, inc);
      checks++; if (st !== 2'd1) begin errors++; $display("FAIL resync_state_%0d: got %0d want 1", i, st); end
    end
    pps_pulse(5, st, stamp, snap, sv, inc);
    checks++; if (st !== 2'd2) begin errors++; $display("FAIL relock_state: got %0d want 2", st); end
  endtask

  task automatic test_missing_pps();
    tick(102);
    checks++; if (bus.sync_state !== 2'd2) begin errors++; $display("FAIL missing_early: got %0d want 2", bus.sync_state); end
    tick(1);
    checks++; if (bus.sync_state !== 2'd0) begin errors++; $display("FAIL missing_state: got %0d want 0", bus.sync_state); end
    checks++; if (bus.gps_connected !== 1'b0) begin errors++; $display("FAIL missing_gps: got %0b want 0", bus.gps_connected); end
    checks++; if (bus.stamp_counter !== ((6 * ONE_S + 64'd608 * INC2) >> 8)) begin errors++; $display("FAIL missing_stamp: got %0h want %0h", bus.stamp_counter, (6 * ONE_S + 64'd608 * INC2) >> 8); end
    tick(10);
    checks++; if (bus.stamp_counter !== ((6 * ONE_S + 64'd618 * INC2) >> 8)) begin errors++; $display("FAIL missing_advance: got %0h want %0h", bus.stamp_counter, (6 * ONE_S + 64'd618 * INC2) >> 8); end
  endtask

  task automatic test_no_correction();
    logic [1:0] st; logic [63:0] stamp, snap; logic sv; logic [39:0] inc;
    do_reset();
    for (int i = 0; i < 5; i++) pps_pulse(100, st, stamp, snap, sv, inc);
    checks++; if (st !== 2'd2) begin errors++; $display("FAIL nocorr_state: got %0d want 2", st); end
    checks++; if (stamp !== ((64'd404 * INC0) >> 8)) begin errors++; $display("FAIL nocorr_stamp: got %0h want %0h", stamp, (64'd404 * INC0) >> 8); end
    checks++; if (snap !== ((64'd403 * INC0) >> 8)) begin errors++; $display("FAIL nocorr_snapshot: got %0h want %0h", snap, (64'd403 * INC0) >> 8); end
    checks++; if (inc !== INC0[39:0]) begin errors++; $display("FAIL nocorr_inc: got %0d want %0d", inc, INC0); end
  endtask

  task automatic test_load_vs_pps();
    logic [1:0] st; logic [63:0] stamp, snap; logic sv; logic [39:0] inc;
    logic [63:0] loadv;
    loadv = 64'h0000_0005_8000_0000;
    do_reset();
    bus.correction_mode = 1'b1;
    for (int i = 0; i < 4; i++) pps_pulse(100, st, stamp, snap, sv, inc);
    pps_rx = 1'b1;
    tick(3);
    bus.load_valid = 1'b1;
    bus.load_value = loadv;
    tick(1);
    bus.load_valid = 1'b0;
    checks++; if (bus.stamp_counter !== loadv) begin errors++; $display("FAIL load_wins_stamp: got %0h want %0h", bus.stamp_counter, loadv); end
    checks++; if (bus.pps_snapshot !== ((64'd403 * INC0) >> 8)) begin errors++; $display("FAIL load_snapshot: got %0h want %0h", bus.pps_snapshot, (64'd403 * INC0) >> 8); end
    checks++; if (bus.sync_state !== 2'd2) begin errors++; $display("FAIL load_state: got %0d want 2", bus.sync_state); end
    checks++; if (bus.cur_inc !== INC1[39:0]) begin errors++; $display("FAIL load_trim: got %0d want %0d", bus.cur_inc, INC1); end
    tick(1);
    checks++; if (bus.stamp_counter !== (((loadv << 8) + INC1) >> 8)) begin errors++; $display("FAIL load_advance: got %0h want %0h", bus.stamp_counter, ((loadv << 8) + INC1) >> 8); end
    pps_rx = 1'b0;
    tick(5);
  endtask

  task automatic test_inc_clamp();
    logic [1:0] st; logic [63:0] stamp, snap; logic sv; logic [39:0] inc;
    do_reset();
    bus.correction_mode = 1'b1;
    bus.cfg_inc_valid   = 1'b1;
    bus.cfg_inc         = '0;
    tick(1);
    bus.cfg_inc_valid = 1'b0;
    checks++; if (bus.cur_inc !== 40'd1) begin errors++; $display("FAIL cfg_zero_clamp: got %0d want 1", bus.cur_inc); end
    for (int i = 0; i < 4; i++) pps_pulse(100, st, stamp, snap, sv, inc);
    pps_rx = 1'b1;
    tick(2);
    bus.load_valid = 1'b1;
    bus.load_value = 64'h0000_0007_0000_0010;
    tick(1);
    bus.load_valid = 1'b0;
    tick(1);
    checks++; if (bus.cur_inc !== 40'd1) begin errors++; $display("FAIL inc_floor: got %0d want 1", bus.cur_inc); end
    checks++; if (bus.stamp_counter !== 64'h7_0000_0000) begin errors++; $display("FAIL floor_snap_stamp: got %0h want 700000000", bus.stamp_counter); end
    checks++; if (bus.pps_snapshot !== 64'h7_0000_0010) begin errors++; $display("FAIL floor_snapshot: got %0h want 700000010", bus.pps_snapshot); end
    tick(1);
    pps_rx = 1'b0;
    tick(5);
  endtask

  initial begin
    pps_rx = 1'b0;
    resetn = 1'b0;
    test_reset();
    test_free_run();
    test_lock_and_snap();
    test_bad_period();
    test_missing_pps();
    test_no_correction();
    test_load_vs_pps();
    test_inc_clamp();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
